// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states, byte-enable constants.
package lsu_ctrl_pkg;

    // Access size codes, identical to the encoding produced by Control.
    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10,
        SizeBad  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StResp   = 2'b10
    } state_e;

    localparam logic [3:0] BeByte = 4'b0001;
    localparam logic [3:0] BeHalf = 4'b0011;
    localparam logic [3:0] BeWord = 4'b1111;

    // A request is rejected when it asks for both directions, uses the reserved size,
    // or is not naturally aligned for its size.
    function automatic logic access_illegal(input logic       rd,
                                            input logic       wr,
                                            input logic [1:0] size,
                                            input logic [1:0] off);
        logic bad;
        bad = rd & wr;
        case (size)
            SizeByte: ;
            SizeHalf: bad = bad | off[0];
            SizeWord: bad = bad | (off != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory request/acknowledge port.
interface lsu_ctrl_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Lane steering: store byte enables and replicated data, load field extract and extension.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_raw,
    output logic [3:0]  be,
    output logic [31:0] st_data,
    output logic [31:0] ld_data
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_sign;

    // Store side: replicate data across lanes so the enabled lanes see the right bytes.
    always_comb begin
        be      = BeWord;
        st_data = st_wdata;
        case (st_size)
            SizeByte: begin
                be      = BeByte << st_off;
                st_data = {4{st_wdata[7:0]}};
            end
            SizeHalf: begin
                be      = BeHalf << st_off;
                st_data = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed field and sign- or zero-extend it.
    always_comb begin
        ld_byte = ld_raw[{ld_off, 3'b000} +: 8];
        ld_half = ld_raw[{ld_off[1], 4'b0000} +: 16];
        ld_sign = 1'b0;
        ld_data = ld_raw;
        case (ld_size)
            SizeByte: begin
                ld_sign = ~ld_unsigned & ld_byte[7];
                ld_data = {{24{ld_sign}}, ld_byte};
            end
            SizeHalf: begin
                ld_sign = ~ld_unsigned & ld_half[15];
                ld_data = {{16{ld_sign}}, ld_half};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: alignment check, one bus access per instruction, pipeline stall.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        inst_size,
    input  logic              load_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              fault_misalign,
    output logic              fault_bus,
    lsu_ctrl_if.master        dmem
);
    localparam int unsigned     CntW    = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              start, illegal, timeout;
    logic              we_q, uns_q, fmis_q, fbus_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q, size_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [CntW-1:0]   cnt_q;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata, al_rdata;

    assign start   = mem_read | mem_write;
    assign illegal = access_illegal(mem_read, mem_write, inst_size, addr[1:0]);
    assign timeout = (cnt_q == CntLast);

    lsu_align u_align (
        .st_size     (inst_size),
        .st_off      (addr[1:0]),
        .st_wdata    (wdata),
        .ld_size     (size_q),
        .ld_off      (off_q),
        .ld_unsigned (uns_q),
        .ld_raw      (dmem.rdata),
        .be          (al_be),
        .st_data     (al_wdata),
        .ld_data     (al_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next state: faults skip the bus; ack takes priority over timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = illegal ? StResp : StAccess;
            StAccess: if (dmem.ack || timeout) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Capture the request on issue, then the response or timeout during the access.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            fmis_q  <= 1'b0;
            fbus_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        cnt_q   <= '0;
                        fmis_q  <= illegal;
                        fbus_q  <= 1'b0;
                        rdata_q <= '0;
                        if (!illegal) begin
                            we_q    <= mem_write;
                            addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                            off_q   <= addr[1:0];
                            size_q  <= inst_size;
                            uns_q   <= load_unsigned;
                            be_q    <= al_be;
                            wdata_q <= al_wdata;
                        end
                    end
                end
                StAccess: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (dmem.ack)    rdata_q <= we_q ? '0 : al_rdata;
                    else if (timeout) fbus_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs: bus fields only during ACCESS, results only during RESP.
    always_comb begin
        stall          = 1'b0;
        done           = 1'b0;
        rdata          = '0;
        fault_misalign = 1'b0;
        fault_bus      = 1'b0;
        dmem.req       = 1'b0;
        dmem.we        = 1'b0;
        dmem.addr      = '0;
        dmem.be        = 4'b0000;
        dmem.wdata     = '0;
        case (state_q)
            StIdle: stall = start;
            StAccess: begin
                stall      = 1'b1;
                dmem.req   = 1'b1;
                dmem.we    = we_q;
                dmem.addr  = addr_q;
                dmem.be    = be_q;
                dmem.wdata = wdata_q;
            end
            StResp: begin
                done           = 1'b1;
                rdata          = rdata_q;
                fault_misalign = fmis_q;
                fault_bus      = fbus_q;
            end
            default: ;
        endcase
    end
endmodule
